multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: Moore FSM plus combinational immediate-format select.
// Optional build macro ILLEGAL_TRAP_EN makes Op=11 a sticky trap; without it Op=11 is a one-cycle NOP.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       InstrDone,
  output logic       Trap
);

  // state  | meaning
  // FETCH  | read instruction, PC += 4
  // DECODE | read registers, classify by Op
  // MEMADR | compute load/store address
  // MEMRD  | read data memory
  // MEMWB  | write loaded word to register file
  // MEMWR  | write data memory
  // EXECR  | ALU op, register operand
  // EXECI  | ALU op, immediate operand
  // ALUWB  | write ALU result to register file
  // BRANCH | load branch target into PC
  // TRAP   | illegal opcode (sticky or NOP depending on build)
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  state_t state, state_next;
  logic   is_cmp;
  logic   reg_w_raw, mem_w_raw, branch_raw;
  logic   ir_write_raw, next_pc_raw, done_raw, trap_raw;

  // CMP/CMN (1010, 1011) only set flags, so they skip write-back
  assign is_cmp = (Funct[4:2] == 3'b101);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_next = S_MEMADR;
          2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = S_FETCH;
      S_EXECR,
      S_EXECI:  state_next = is_cmp ? S_FETCH : S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`else
      S_TRAP:   state_next = S_FETCH;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch_raw   = 1'b0;
    done_raw     = 1'b0;
    trap_raw     = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUOp        = 1'b0;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ImmSrc       = (Op == 2'b11) ? 2'b00 : Op;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
        done_raw  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
        done_raw  = 1'b1;
      end
      S_EXECR: begin
        ALUOp    = 1'b1;
        done_raw = is_cmp;
      end
      S_EXECI: begin
        ALUSrcB  = 2'b01;
        ALUOp    = 1'b1;
        done_raw = is_cmp;
      end
      S_ALUWB: begin
        reg_w_raw = 1'b1;
        done_raw  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_raw = 1'b1;
        done_raw   = 1'b1;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        trap_raw = 1'b1;
        ImmSrc   = 2'b00;
`else
        done_raw = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Reset forces enables low combinationally so an aborted instruction writes nothing
  assign IRWrite   = reset_n & ir_write_raw;
  assign NextPC    = reset_n & next_pc_raw;
  assign RegW      = reset_n & reg_w_raw  & CondEx;
  assign MemW      = reset_n & mem_w_raw  & CondEx;
  assign Branch    = reset_n & branch_raw & CondEx;
  assign InstrDone = reset_n & done_raw;
  assign Trap      = reset_n & trap_raw;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl; expectations come from per-class
// phase lists and an output table built from the instruction latencies and output rules.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       CondEx;
  logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc;
  logic       InstrDone, Trap;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .CondEx(CondEx),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .InstrDone(InstrDone), .Trap(Trap)
  );

  always #5 clk = ~clk;

  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MWR = 5,
                 PH_EXR = 6, PH_EXI = 7, PH_WB = 8, PH_BR = 9, PH_T = 10;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp,
            ALUSrcB, ResultSrc, ImmSrc, InstrDone, Trap};
  endfunction

  function automatic int instr_len(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return f[0] ? 5 : 4;
    if (op == 2'b00) return (f[4:1] == 4'b1010 || f[4:1] == 4'b1011) ? 3 : 4;
    return 3;
  endfunction

  function automatic int phase_at(input logic [1:0] op, input logic [5:0] f, input int idx);
    case (idx)
      0: return PH_F;
      1: return PH_D;
      2: case (op)
           2'b01:   return PH_MA;
           2'b00:   return f[5] ? PH_EXI : PH_EXR;
           2'b10:   return PH_BR;
           default: return PH_T;
         endcase
      3: if (op == 2'b01) return f[0] ? PH_MR : PH_MWR;
         else return PH_WB;
      default: return PH_MWB;
    endcase
  endfunction

  function automatic logic [15:0] model(input int ph, input logic [1:0] op,
                                        input logic cx, input logic done);
    logic ir, npc, rw, mw, br, adr, asa, aop, trp;
    logic [1:0] asb, rs, imm;
    {ir, npc, rw, mw, br, adr, asa, aop, trp} = '0;
    asb = 2'b00; rs = 2'b00;
    imm = (op == 2'b11) ? 2'b00 : op;
    case (ph)
      PH_F:   begin ir = 1; npc = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
      PH_D:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
      PH_MA:  asb = 2'b01;
      PH_MR:  adr = 1;
      PH_MWB: begin rs = 2'b01; rw = 1; end
      PH_MWR: begin adr = 1; mw = 1; end
      PH_EXR: aop = 1;
      PH_EXI: begin asb = 2'b01; aop = 1; end
      PH_WB:  rw = 1;
      PH_BR:  begin asb = 2'b01; rs = 2'b10; br = 1; end
`ifdef ILLEGAL_TRAP_EN
      PH_T:   begin trp = 1; imm = 2'b00; done = 1'b0; end
`endif
      default: ;
    endcase
    return {ir, npc, rw & cx, mw & cx, br & cx, adr, asa, aop, asb, rs, imm, done, trp};
  endfunction

  // cx_mode: 0/1 forces CondEx, 2 randomizes per cycle. abort_idx >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input int cx_mode,
                           input string tag, input int abort_idx);
    int n;
    n = instr_len(op, f);
    for (int idx = 0; idx < n; idx++) begin
      @(negedge clk);
      if (idx == 1 || idx == 2) begin
        Op = op; Funct = f;
      end else begin
        Op = 2'($urandom_range(0, 3)); Funct = 6'($urandom_range(0, 63));
      end
      CondEx = (cx_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(cx_mode);
      #1;
      check_val($sformatf("%s_c%0d", tag, idx), 32'(outs()),
                32'(model(phase_at(op, f, idx), Op, CondEx, idx == n - 1)));
      if (idx == abort_idx) begin
        reset_n = 1'b0;
        #1;
        check_val({tag, "_abort_en"}, 32'({IRWrite, NextPC, RegW, MemW, Branch, InstrDone, Trap}), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check_val({tag, "_abort_fetch"}, 32'(outs()), 32'(model(PH_F, Op, CondEx, 1'b0)));
        return;
      end
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [5:0] rf;
    reset_n = 1'b0; Op = 2'b00; Funct = 6'd0; CondEx = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_val("reset_en", 32'({IRWrite, NextPC, RegW, MemW, Branch, InstrDone, Trap}), 32'd0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check_val("release_fetch", 32'(outs()), 32'(model(PH_F, Op, CondEx, 1'b0)));

    run_instr(2'b01, 6'b011001, 1, "ldr",  -1);
    run_instr(2'b00, 6'b101000, 2, "addi", -1);
    run_instr(2'b00, 6'b110101, 2, "cmp",  -1);
    run_instr(2'b10, 6'b000000, 0, "b_nc", -1);
    run_instr(2'b01, 6'b011000, 1, "str",  -1);
    run_instr(2'b00, 6'b001000, 1, "addr", -1);
    run_instr(2'b00, 6'b010110, 1, "cmnr", -1);
    run_instr(2'b01, 6'b011000, 1, "str_rst", 3);
    run_instr(2'b01, 6'b011001, 1, "ldr_rst", 4);
    run_instr(2'b01, 6'b011001, 2, "post_rst", -1);
`ifndef ILLEGAL_TRAP_EN
    run_instr(2'b11, 6'b000000, 2, "trap_nop", -1);
`endif

    for (int i = 0; i < 300; i++) begin
`ifdef ILLEGAL_TRAP_EN
      rop = 2'($urandom_range(0, 2));
`else
      rop = 2'($urandom_range(0, 3));
`endif
      rf = 6'($urandom_range(0, 63));
      run_instr(rop, rf, 2, "rnd", -1);
    end

`ifdef ILLEGAL_TRAP_EN
    run_instr(2'b11, 6'b000000, 2, "trap", 1);
    for (int idx = 0; idx < 2; idx++) begin
      @(negedge clk);
      Op = 2'b11; Funct = 6'($urandom_range(0, 63)); CondEx = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      Op = 2'($urandom_range(0, 3)); Funct = 6'($urandom_range(0, 63));
      CondEx = 1'($urandom_range(0, 1));
      #1 check_val("trap_sticky", 32'(outs()), 32'(model(PH_T, Op, CondEx, 1'b0)));
    end
    reset_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    run_instr(2'b10, 6'b000000, 1, "after_trap", -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
